// File: rtl/axi_crossbar_wch_sequencer.sv
// W-channel ordering controller for one crossbar slave port: queues {master, AWLEN}
// per accepted AW and grants W to one master at a time, strictly in AW order.
module axi_crossbar_wch_sequencer #(
  parameter int MST_NB     = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 8,
  parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              aclk,
  input  logic              srst,
  input  logic [MST_NB-1:0] aw_grant,
  input  logic              aw_hs,
  input  logic [LEN_W-1:0]  aw_len,
  output logic              aw_stall,
  output logic [MST_NB-1:0] w_grant,
  input  logic              w_hs,
  input  logic              w_last,
  output logic              len_err,
  output logic              err_drop,
  output logic [CNT_W-1:0]  outstanding
);

  localparam int IDX_W = (MST_NB > 1) ? $clog2(MST_NB) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [IDX_W-1:0] idx_mem [FIFO_DEPTH];
  logic [LEN_W-1:0] len_mem [FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LEN_W:0]   beat_q, beat_d;
  logic             len_err_q, len_err_d;
  logic             err_drop_q, err_drop_d;

  logic [IDX_W-1:0] aw_idx;
  logic [IDX_W-1:0] head_idx;
  logic [LEN_W-1:0] head_len;
  logic             full, empty, push, pop, w_active, cnt_match;

  // Lowest set bit wins when the AW grant is not one-hot.
  always_comb begin
    aw_idx = '0;
    for (int i = MST_NB - 1; i >= 0; i--) begin
      if (aw_grant[i]) aw_idx = IDX_W'(i);
    end
  end

  assign full      = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign empty     = (cnt_q == '0);
  assign head_idx  = idx_mem[rd_ptr_q];
  assign head_len  = len_mem[rd_ptr_q];

  assign push      = aw_hs && !full && (aw_grant != '0);
  assign w_active  = w_hs && !empty;
  assign cnt_match = (beat_q == {1'b0, head_len});
  // A burst ends on WLAST or when the beat count reaches AWLEN, whichever comes first.
  assign pop       = w_active && (w_last || cnt_match);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    beat_d     = beat_q;
    err_drop_d = err_drop_q;
    len_err_d  = w_active && (w_last != cnt_match);

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    if (pop)           beat_d = '0;
    else if (w_active) beat_d = beat_q + (LEN_W + 1)'(1);

    if (aw_hs && (full || (aw_grant == '0))) err_drop_d = 1'b1;
  end

  always_ff @(posedge aclk) begin
    if (srst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      beat_q     <= '0;
      len_err_q  <= 1'b0;
      err_drop_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      beat_q     <= beat_d;
      len_err_q  <= len_err_d;
      err_drop_q <= err_drop_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (!srst && push) begin
      idx_mem[wr_ptr_q] <= aw_idx;
      len_mem[wr_ptr_q] <= aw_len;
    end
  end

  // Grant decodes only registered state, so the switch sees no input-to-select path.
  generate
    for (genvar gi = 0; gi < MST_NB; gi++) begin : g_grant
      assign w_grant[gi] = !empty && (head_idx == IDX_W'(gi));
    end
  endgenerate

  assign aw_stall    = full;
  assign len_err     = len_err_q;
  assign err_drop    = err_drop_q;
  assign outstanding = cnt_q;

endmodule

// File: tb/tb_axi_crossbar_wch_sequencer.sv
// Directed bench for the W-channel sequencer: ordering, full/drop, simultaneous
// push/pop, length errors, pointer wrap and mid-burst reset.
module tb_axi_crossbar_wch_sequencer;

  logic       aclk = 1'b0;
  logic       srst = 1'b1;
  logic [2:0] aw_grant = '0;
  logic       aw_hs = 1'b0;
  logic [7:0] aw_len = '0;
  logic       aw_stall;
  logic [2:0] w_grant;
  logic       w_hs = 1'b0;
  logic       w_last = 1'b0;
  logic       len_err;
  logic       err_drop;
  logic [2:0] outstanding;

  int errors = 0;
  int checks = 0;

  axi_crossbar_wch_sequencer dut (
    .aclk(aclk), .srst(srst), .aw_grant(aw_grant), .aw_hs(aw_hs), .aw_len(aw_len),
    .aw_stall(aw_stall), .w_grant(w_grant), .w_hs(w_hs), .w_last(w_last),
    .len_err(len_err), .err_drop(err_drop), .outstanding(outstanding)
  );

  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    srst = 1'b1; tick(); tick(); srst = 1'b0;
  endtask

  task automatic push(input logic [2:0] g, input logic [7:0] l);
    aw_grant = g; aw_len = l; aw_hs = 1'b1;
    tick();
    aw_hs = 1'b0; aw_grant = '0; aw_len = '0;
  endtask

  task automatic wbeat(input logic last);
    w_hs = 1'b1; w_last = last;
    tick();
    w_hs = 1'b0; w_last = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({w_grant, outstanding, aw_stall, len_err, err_drop} !== 9'b0) begin
      errors++;
      $display("FAIL reset_state: got grant=%b out=%0d stall=%b len_err=%b drop=%b, want all 0",
               w_grant, outstanding, aw_stall, len_err, err_drop);
    end
    $display("reset: grant=%b out=%0d", w_grant, outstanding);
  endtask

  task automatic test_ordering();
    int bad_len_err = 0;
    do_reset();
    aw_grant = 3'b100; aw_len = 8'd1; aw_hs = 1'b1;
    #1;
    checks++;
    if (w_grant !== 3'b000) begin
      errors++; $display("FAIL order_no_bypass: got %b want 000", w_grant);
    end
    tick();
    aw_hs = 1'b0;
    checks++;
    if (w_grant !== 3'b100) begin
      errors++; $display("FAIL order_first_grant: got %b want 100", w_grant);
    end
    push(3'b001, 8'd0);
    push(3'b010, 8'd2);
    checks++;
    if (outstanding !== 3'd3) begin
      errors++; $display("FAIL order_outstanding: got %0d want 3", outstanding);
    end
    wbeat(1'b0); if (len_err) bad_len_err++;
    checks++;
    if (w_grant !== 3'b100) begin
      errors++; $display("FAIL order_mid_burst: got %b want 100", w_grant);
    end
    wbeat(1'b1); if (len_err) bad_len_err++;
    checks++;
    if (w_grant !== 3'b001) begin
      errors++; $display("FAIL order_second: got %b want 001", w_grant);
    end
    wbeat(1'b1); if (len_err) bad_len_err++;
    checks++;
    if (w_grant !== 3'b010) begin
      errors++; $display("FAIL order_third: got %b want 010", w_grant);
    end
    wbeat(1'b0); if (len_err) bad_len_err++;
    wbeat(1'b0); if (len_err) bad_len_err++;
    wbeat(1'b1); if (len_err) bad_len_err++;
    checks++;
    if (w_grant !== 3'b000 || outstanding !== 3'd0) begin
      errors++; $display("FAIL order_drained: got grant=%b out=%0d want 000/0", w_grant, outstanding);
    end
    checks++;
    if (bad_len_err != 0) begin
      errors++; $display("FAIL order_len_err: got %0d pulses want 0", bad_len_err);
    end
    $display("ordering: final grant=%b out=%0d", w_grant, outstanding);
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 4; i++) push(3'b001, 8'd0);
    checks++;
    if (aw_stall !== 1'b1 || outstanding !== 3'd4 || err_drop !== 1'b0) begin
      errors++; $display("FAIL full_stall: got stall=%b out=%0d drop=%b want 1/4/0", aw_stall, outstanding, err_drop);
    end
    push(3'b010, 8'd0);
    checks++;
    if (err_drop !== 1'b1 || outstanding !== 3'd4) begin
      errors++; $display("FAIL full_drop: got drop=%b out=%0d want 1/4", err_drop, outstanding);
    end
    wbeat(1'b1);
    checks++;
    if (aw_stall !== 1'b0 || outstanding !== 3'd3) begin
      errors++; $display("FAIL full_release: got stall=%b out=%0d want 0/3", aw_stall, outstanding);
    end
    // Zero grant is dropped; a non-one-hot grant resolves to its lowest bit.
    do_reset();
    push(3'b000, 8'd0);
    checks++;
    if (err_drop !== 1'b1 || outstanding !== 3'd0) begin
      errors++; $display("FAIL zero_grant_drop: got drop=%b out=%0d want 1/0", err_drop, outstanding);
    end
    push(3'b110, 8'd0);
    checks++;
    if (w_grant !== 3'b010) begin
      errors++; $display("FAIL lowest_bit: got %b want 010", w_grant);
    end
    $display("full: stall=%b out=%0d drop=%b", aw_stall, outstanding, err_drop);
  endtask

  task automatic test_simultaneous();
    do_reset();
    push(3'b001, 8'd0);
    push(3'b100, 8'd1);
    aw_grant = 3'b010; aw_len = 8'd0; aw_hs = 1'b1; w_hs = 1'b1; w_last = 1'b1;
    tick();
    aw_hs = 1'b0; aw_grant = '0; w_hs = 1'b0; w_last = 1'b0;
    checks++;
    if (outstanding !== 3'd2 || w_grant !== 3'b100) begin
      errors++; $display("FAIL simul_push_pop: got out=%0d grant=%b want 2/100", outstanding, w_grant);
    end
    wbeat(1'b0);
    wbeat(1'b1);
    checks++;
    if (w_grant !== 3'b010) begin
      errors++; $display("FAIL simul_tail: got %b want 010", w_grant);
    end
    wbeat(1'b1);
    // Full plus pop on the same edge: the push is still dropped.
    for (int i = 0; i < 4; i++) push(3'b100, 8'd0);
    aw_grant = 3'b001; aw_hs = 1'b1; w_hs = 1'b1; w_last = 1'b1;
    tick();
    aw_hs = 1'b0; aw_grant = '0; w_hs = 1'b0; w_last = 1'b0;
    checks++;
    if (outstanding !== 3'd3 || err_drop !== 1'b1) begin
      errors++; $display("FAIL full_push_pop: got out=%0d drop=%b want 3/1", outstanding, err_drop);
    end
    $display("simultaneous: out=%0d drop=%b", outstanding, err_drop);
  endtask

  task automatic test_len_err();
    do_reset();
    push(3'b001, 8'd3);
    push(3'b100, 8'd0);
    push(3'b010, 8'd0);
    wbeat(1'b0);
    wbeat(1'b1);
    checks++;
    if (len_err !== 1'b1 || w_grant !== 3'b100 || outstanding !== 3'd2) begin
      errors++; $display("FAIL early_wlast: got len_err=%b grant=%b out=%0d want 1/100/2", len_err, w_grant, outstanding);
    end
    tick();
    checks++;
    if (len_err !== 1'b0) begin
      errors++; $display("FAIL early_wlast_pulse: got %b want 0", len_err);
    end
    wbeat(1'b0);
    checks++;
    if (len_err !== 1'b1 || w_grant !== 3'b010 || outstanding !== 3'd1) begin
      errors++; $display("FAIL missing_wlast: got len_err=%b grant=%b out=%0d want 1/010/1", len_err, w_grant, outstanding);
    end
    wbeat(1'b1);
    checks++;
    if (len_err !== 1'b0 || w_grant !== 3'b000) begin
      errors++; $display("FAIL len_normal_after: got len_err=%b grant=%b want 0/000", len_err, w_grant);
    end
    $display("len_err: grant=%b out=%0d", w_grant, outstanding);
  endtask

  task automatic test_wrap();
    logic [2:0] exp;
    do_reset();
    for (int i = 0; i < 3; i++) push(3'b001 << i, 8'd0);
    for (int k = 0; k < 10; k++) begin
      exp = 3'b001 << (k % 3);
      checks++;
      if (w_grant !== exp) begin
        errors++; $display("FAIL wrap_grant_%0d: got %b want %b", k, w_grant, exp);
      end
      if (k + 3 < 10) begin
        aw_grant = 3'b001 << ((k + 3) % 3); aw_hs = 1'b1;
      end
      w_hs = 1'b1; w_last = 1'b1;
      tick();
      aw_hs = 1'b0; aw_grant = '0; w_hs = 1'b0; w_last = 1'b0;
    end
    checks++;
    if (w_grant !== 3'b000 || outstanding !== 3'd0 || len_err !== 1'b0) begin
      errors++; $display("FAIL wrap_drained: got grant=%b out=%0d len_err=%b want 000/0/0", w_grant, outstanding, len_err);
    end
    $display("wrap: 10 bursts, final out=%0d", outstanding);
  endtask

  task automatic test_reset_midburst();
    do_reset();
    push(3'b000, 8'd0);
    push(3'b001, 8'd2);
    push(3'b010, 8'd0);
    wbeat(1'b0);
    do_reset();
    checks++;
    if ({w_grant, outstanding, aw_stall, len_err, err_drop} !== 9'b0) begin
      errors++;
      $display("FAIL reset_midburst: got grant=%b out=%0d stall=%b len_err=%b drop=%b, want all 0",
               w_grant, outstanding, aw_stall, len_err, err_drop);
    end
    wbeat(1'b1);
    checks++;
    if (outstanding !== 3'd0 || len_err !== 1'b0) begin
      errors++; $display("FAIL w_while_empty: got out=%0d len_err=%b want 0/0", outstanding, len_err);
    end
    push(3'b100, 8'd0);
    wbeat(1'b1);
    checks++;
    if (len_err !== 1'b0 || w_grant !== 3'b000) begin
      errors++; $display("FAIL beat_cnt_cleared: got len_err=%b grant=%b want 0/000", len_err, w_grant);
    end
    $display("reset_midburst: out=%0d drop=%b", outstanding, err_drop);
  endtask

  initial begin
    test_reset();
    test_ordering();
    test_full();
    test_simultaneous();
    test_len_err();
    test_wrap();
    test_reset_midburst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
